// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared definitions for both ends of the PPM optical link: the protocol
// state encoding, link framing constants and the derived default re-send
// timeout.
//
// Contents:
//   state_e          protocol FSM states (WAIT_RX, CHECK, SETTLE, ARM, BUSY)
//   N_PKT_DEFAULT    default packet width in bits
//   L, N_MOD,        PPM framing constants used to size the timeout
//   PRE_CT,
//   HISTORY_SIZE
//   timeout_cycles() default number of cycles to wait before re-sending
// -----------------------------------------------------------------------------
package player_pkg;

    typedef enum logic [2:0] {
        WAIT_RX = 3'd0,
        CHECK   = 3'd1,
        SETTLE  = 3'd2,
        ARM     = 3'd3,
        BUSY    = 3'd4
    } state_e;

    localparam int N_PKT_DEFAULT = 8;
    localparam int L             = 60;
    localparam int N_MOD         = 2;
    localparam int PRE_CT        = 2;
    localparam int HISTORY_SIZE  = 5;

    // Worst-case time for one packet to cross the link and be decoded, plus
    // margin for the decoder history window.
    function automatic int timeout_cycles();
        return (2**N_MOD * L) * (PRE_CT + N_PKT_DEFAULT / N_MOD) + 5 * HISTORY_SIZE;
    endfunction

endpackage

// File: rtl/player2_responder_timer.sv
// -----------------------------------------------------------------------------
// response_timer
// Clear/enable counter that flags when TIMEOUT cycles of enabled counting
// have elapsed since the last clear. Saturates at TIMEOUT-1 so the expire
// flag stays up until the owner clears it. Shared by both link players.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   clear_i   in   restart the count from zero (wins over enable_i)
//   enable_i  in   count this cycle
//   expire_o  out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module response_timer
    import player_pkg::*;
#(
    parameter int TIMEOUT = timeout_cycles()
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign expire_o = (count_q == TW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expire_o) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/player2_responder.sv
// -----------------------------------------------------------------------------
// player2_responder
// Responding end of the PPM optical link. Each decoded packet is compared
// with the locally expected LFSR value. A match pulses
// expected_data_received (which advances the LFSR), waits for the LFSR to
// settle and transmits the fresh data2send. A malformed or mismatching
// packet, or silence for TIMEOUT cycles after a transmission, re-sends the
// last response.
//
// Optional build macro: RESPONDER_STATS_EN enables the good/bad/resend
// statistics counters; without it those ports are tied to zero.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   data2send                next response value from the LFSR
//   data_expected            value the initiator should have sent
//   expected_data_received   one-cycle pulse on a matching packet
//   data_DEC, avail_DEC,     decoder packet, packet-present flag and
//   error_DEC                malformed flag
//   read_DEC                 one-cycle decoder consume strobe
//   data_ENC                 packet to transmit, stable while encoding
//   start_ENC                one-cycle encoder start strobe
//   avail_ENC                encoder idle
//   good_count, bad_count,   statistics counters
//   resend_count
// -----------------------------------------------------------------------------
module player2_responder
    import player_pkg::*;
#(
    parameter int N_PKT   = N_PKT_DEFAULT,
    parameter int TIMEOUT = timeout_cycles(),
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PKT-1:0] data2send,
    input  logic [N_PKT-1:0] data_expected,
    output logic             expected_data_received,
    input  logic [N_PKT-1:0] data_DEC,
    input  logic             avail_DEC,
    input  logic             error_DEC,
    output logic             read_DEC,
    output logic [N_PKT-1:0] data_ENC,
    output logic             start_ENC,
    input  logic             avail_ENC,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count,
    output logic [CNT_W-1:0] resend_count
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state_q,    state_d;
    logic [N_PKT-1:0] rx_data_q,  rx_data_d;
    logic             rx_err_q,   rx_err_d;
    logic             resend_q,   resend_d;
    logic [SW-1:0]    settle_q,   settle_d;
    logic             seen_low_q, seen_low_d;
    logic             has_sent_q, has_sent_d;
    logic [N_PKT-1:0] last_tx_q,  last_tx_d;
    logic [N_PKT-1:0] data_enc_q, data_enc_d;
    logic             read_q,     read_d;
    logic             start_q,    start_d;
    logic             match_q,    match_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expire;
    logic good_inc;
    logic bad_inc;
    logic resend_inc;

    // The re-send timer only runs while idle waiting for the initiator, and
    // only once there is something to re-send.
    assign timer_en = (state_q == WAIT_RX) && has_sent_q;

    response_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    // Next-state and registered-output logic. A waiting packet always wins
    // over a timer expiry in the same cycle. In ARM, a re-send with nothing
    // sent yet falls back to data2send, and only a real re-send is counted.
    always_comb begin
        state_d     = state_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;
        resend_d    = resend_q;
        settle_d    = settle_q;
        seen_low_d  = seen_low_q;
        has_sent_d  = has_sent_q;
        last_tx_d   = last_tx_q;
        data_enc_d  = data_enc_q;
        read_d      = 1'b0;
        start_d     = 1'b0;
        match_d     = 1'b0;
        timer_clear = 1'b0;
        good_inc    = 1'b0;
        bad_inc     = 1'b0;
        resend_inc  = 1'b0;

        case (state_q)
            WAIT_RX: begin
                if (avail_DEC) begin
                    read_d    = 1'b1;
                    rx_data_d = data_DEC;
                    rx_err_d  = error_DEC;
                    state_d   = CHECK;
                end else if (has_sent_q && timer_expire) begin
                    resend_d = 1'b1;
                    state_d  = ARM;
                end
            end

            CHECK: begin
                if (!rx_err_q && (rx_data_q == data_expected)) begin
                    match_d  = 1'b1;
                    good_inc = 1'b1;
                    settle_d = '0;
                    state_d  = player_pkg::SETTLE;
                end else begin
                    bad_inc  = 1'b1;
                    resend_d = 1'b1;
                    state_d  = ARM;
                end
            end

            player_pkg::SETTLE: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    resend_d = 1'b0;
                    state_d  = ARM;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            ARM: begin
                if (avail_ENC) begin
                    if (resend_q && has_sent_q) begin
                        data_enc_d = last_tx_q;
                        last_tx_d  = last_tx_q;
                        resend_inc = 1'b1;
                    end else begin
                        data_enc_d = data2send;
                        last_tx_d  = data2send;
                    end
                    start_d    = 1'b1;
                    has_sent_d = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = BUSY;
                end
            end

            BUSY: begin
                if (!avail_ENC) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    timer_clear = 1'b1;
                    state_d     = WAIT_RX;
                end
            end

            default: begin
                state_d = WAIT_RX;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_RX;
            rx_data_q  <= '0;
            rx_err_q   <= 1'b0;
            resend_q   <= 1'b0;
            settle_q   <= '0;
            seen_low_q <= 1'b0;
            has_sent_q <= 1'b0;
            last_tx_q  <= '0;
            data_enc_q <= '0;
            read_q     <= 1'b0;
            start_q    <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            resend_q   <= resend_d;
            settle_q   <= settle_d;
            seen_low_q <= seen_low_d;
            has_sent_q <= has_sent_d;
            last_tx_q  <= last_tx_d;
            data_enc_q <= data_enc_d;
            read_q     <= read_d;
            start_q    <= start_d;
            match_q    <= match_d;
        end
    end

    assign read_DEC               = read_q;
    assign start_ENC              = start_q;
    assign expected_data_received = match_q;
    assign data_ENC               = data_enc_q;

`ifdef RESPONDER_STATS_EN
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] bad_q;
    logic [CNT_W-1:0] resend_cnt_q;

    // Statistics counters; they wrap silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q       <= '0;
            bad_q        <= '0;
            resend_cnt_q <= '0;
        end else begin
            if (good_inc) begin
                good_q <= good_q + CNT_W'(1);
            end
            if (bad_inc) begin
                bad_q <= bad_q + CNT_W'(1);
            end
            if (resend_inc) begin
                resend_cnt_q <= resend_cnt_q + CNT_W'(1);
            end
        end
    end

    assign good_count   = good_q;
    assign bad_count    = bad_q;
    assign resend_count = resend_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = good_inc ^ bad_inc ^ resend_inc;

    assign good_count   = '0;
    assign bad_count    = '0;
    assign resend_count = '0;
`endif

endmodule

// File: tb/tb_player2_responder.sv
// -----------------------------------------------------------------------------
// tb_player2_responder
// Directed bench for player2_responder with TIMEOUT=20 and SETTLE=2. The
// decoder and encoder handshakes are played by hand from a single linear
// sequence; inputs change and outputs are sampled 1 time unit after each
// rising clock edge. Counter expectations collapse to zero when the design
// is built without RESPONDER_STATS_EN.
// -----------------------------------------------------------------------------
module tb_player2_responder;

    localparam int NPKT = 8;
    localparam int TMO  = 20;
    localparam int STL  = 2;
    localparam int CW   = 32;

`ifdef RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [NPKT-1:0] data2send;
    logic [NPKT-1:0] dataExpected;
    logic            expectedDataReceived;
    logic [NPKT-1:0] dataDec;
    logic            availDec;
    logic            errorDec;
    logic            readDec;
    logic [NPKT-1:0] dataEnc;
    logic            startEnc;
    logic            availEnc;
    logic [CW-1:0]   goodCount;
    logic [CW-1:0]   badCount;
    logic [CW-1:0]   resendCount;

    int checks   = 0;
    int failures = 0;
    logic sawStart;

    player2_responder #(
        .N_PKT   (NPKT),
        .TIMEOUT (TMO),
        .SETTLE  (STL),
        .CNT_W   (CW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .data2send              (data2send),
        .data_expected          (dataExpected),
        .expected_data_received (expectedDataReceived),
        .data_DEC               (dataDec),
        .avail_DEC              (availDec),
        .error_DEC              (errorDec),
        .read_DEC               (readDec),
        .data_ENC               (dataEnc),
        .start_ENC              (startEnc),
        .avail_ENC              (availEnc),
        .good_count             (goodCount),
        .bad_count              (badCount),
        .resend_count           (resendCount)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expCount(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic aDec, input logic [NPKT-1:0] dDec,
                                 input logic eDec);
        availDec = aDec;
        dataDec  = dDec;
        errorDec = eDec;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Plays the encoder after a start strobe: drops avail_ENC the cycle after
    // start, stays busy for busyCycles, then returns to idle. data_ENC must
    // hold the transmitted value throughout.
    task automatic finishTx(input int busyCycles, input logic [NPKT-1:0] txData);
        logic stable;
        stable = 1'b1;
        tick();
        checkOutput("startOneCycle", startEnc, 0);
        availEnc = 1'b0;
        for (int i = 0; i < busyCycles; i++) begin
            tick();
            if (dataEnc !== txData) stable = 1'b0;
        end
        checkOutput("busyDataStable", stable, 1);
        availEnc = 1'b1;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        availEnc     = 1'b1;
        dataExpected = 8'hA5;
        data2send    = 8'h3C;
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rstRead",   readDec, 0);
        checkOutput("rstStart",  startEnc, 0);
        checkOutput("rstPulse",  expectedDataReceived, 0);
        checkOutput("rstData",   dataEnc, 0);
        checkOutput("rstGood",   goodCount, 0);
        checkOutput("rstResend", resendCount, 0);
        rst = 1'b0;

        sawStart = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (startEnc) sawStart = 1'b1;
        end
        checkOutput("idleNoSend", sawStart, 0);

        $display("[TB] match");
        applyStimulus(1'b1, 8'hA5, 1'b0);
        tick();
        checkOutput("matchRead", readDec, 1);
        checkOutput("matchPulseEarly", expectedDataReceived, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("matchPulse", expectedDataReceived, 1);
        checkOutput("matchReadOneCycle", readDec, 0);
        tick();
        checkOutput("matchPulseOneCycle", expectedDataReceived, 0);
        checkOutput("matchSettle1", startEnc, 0);
        tick();
        checkOutput("matchSettle2", startEnc, 0);
        tick();
        checkOutput("matchStart", startEnc, 1);
        checkOutput("matchData", dataEnc, 8'h3C);
        checkOutput("matchGood", goodCount, expCount(1));
        finishTx(3, 8'h3C);

        $display("[TB] mismatch");
        data2send = 8'h99;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        tick();
        checkOutput("mmRead", readDec, 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("mmNoPulse", expectedDataReceived, 0);
        checkOutput("mmStartEarly", startEnc, 0);
        tick();
        checkOutput("mmStart", startEnc, 1);
        checkOutput("mmData", dataEnc, 8'h3C);
        checkOutput("mmBad", badCount, expCount(1));
        checkOutput("mmResend", resendCount, expCount(1));
        checkOutput("mmGood", goodCount, expCount(1));

        $display("[TB] reset mid-busy");
        tick();
        availEnc = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midRstStart",  startEnc, 0);
        checkOutput("midRstRead",   readDec, 0);
        checkOutput("midRstData",   dataEnc, 0);
        checkOutput("midRstGood",   goodCount, 0);
        checkOutput("midRstBad",    badCount, 0);
        checkOutput("midRstResend", resendCount, 0);
        availEnc = 1'b1;
        tick();
        rst = 1'b0;
        sawStart = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (startEnc) sawStart = 1'b1;
        end
        checkOutput("postRstNoSend", sawStart, 0);

        $display("[TB] decoder error before first send");
        data2send = 8'h77;
        applyStimulus(1'b1, 8'hA5, 1'b1);
        tick();
        checkOutput("errRead", readDec, 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("errNoPulse", expectedDataReceived, 0);
        tick();
        checkOutput("errStart", startEnc, 1);
        checkOutput("errData", dataEnc, 8'h77);
        checkOutput("errBad", badCount, expCount(1));
        checkOutput("errResend", resendCount, expCount(0));
        checkOutput("errGood", goodCount, expCount(0));
        finishTx(2, 8'h77);

        $display("[TB] timeout re-send");
        data2send = 8'h11;
        sawStart = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (startEnc) sawStart = 1'b1;
        end
        checkOutput("toEarly", sawStart, 0);
        tick();
        checkOutput("toStart", startEnc, 1);
        checkOutput("toData", dataEnc, 8'h77);
        checkOutput("toResend", resendCount, expCount(1));
        finishTx(2, 8'h77);

        $display("[TB] packet on expiry cycle, then encoder busy");
        sawStart = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (startEnc) sawStart = 1'b1;
        end
        checkOutput("raceEarly", sawStart, 0);
        applyStimulus(1'b1, 8'hA5, 1'b0);
        tick();
        checkOutput("raceRead", readDec, 1);
        checkOutput("raceNoStart", startEnc, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        availEnc = 1'b0;
        tick();
        checkOutput("racePulse", expectedDataReceived, 1);
        sawStart = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (startEnc) sawStart = 1'b1;
        end
        checkOutput("encBusyNoStart", sawStart, 0);
        availEnc = 1'b1;
        tick();
        checkOutput("encStart", startEnc, 1);
        checkOutput("encData", dataEnc, 8'h11);
        checkOutput("encGood", goodCount, expCount(1));
        checkOutput("encBad", badCount, expCount(1));
        data2send = 8'h22;
        finishTx(4, 8'h11);
        checkOutput("finalResend", resendCount, expCount(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
